// File: rtl/sine_voice_scheduler.sv
// Shares one synchronous sine ROM among NUM_VOICES voices: per sample tick it walks every
// voice through address/wait/multiply-accumulate and offers the mixed sum on valid/ready.
module sine_voice_scheduler #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned TABLE_LEN  = 100,
    parameter int unsigned FRAC_W     = 16,
    parameter int unsigned SAMPLE_W   = 8,
    parameter int unsigned AMP_W      = 16,
    parameter int unsigned OUT_W      = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               sample_tick,
    input  logic [NUM_VOICES-1:0]              voice_en,
    input  logic [NUM_VOICES*(7+FRAC_W)-1:0]   phase_inc,
    input  logic [NUM_VOICES*AMP_W-1:0]        amplitude,
    output logic [6:0]                         rom_addr,
    input  logic [SAMPLE_W-1:0]                rom_data,
    output logic [OUT_W-1:0]                   mix_out,
    output logic                               mix_valid,
    input  logic                               mix_ready,
    output logic                               busy,
    output logic                               overrun
);

    localparam int unsigned PHASE_W = 7 + FRAC_W;
    localparam int unsigned VIDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned PROD_W  = SAMPLE_W + AMP_W + 1;
    localparam logic [PHASE_W:0]    PHASE_MOD = (PHASE_W + 1)'(TABLE_LEN) << FRAC_W;
    localparam logic [VIDX_W-1:0]   LAST_V    = VIDX_W'(NUM_VOICES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_MAC,
        S_OUT
    } state_t;

    state_t                     state, state_nxt;
    logic [VIDX_W-1:0]          v_idx;
    logic [PHASE_W-1:0]         phase [NUM_VOICES];
    logic signed [OUT_W-1:0]    sum;

    logic [PHASE_W-1:0]         cur_phase;
    logic [PHASE_W-1:0]         cur_inc;
    logic [AMP_W-1:0]           cur_amp;
    logic                       cur_en;
    logic [PHASE_W:0]           phase_sum;
    logic [PHASE_W-1:0]         phase_wrapped;
    logic signed [PROD_W-1:0]   product;
    logic signed [OUT_W-1:0]    sum_nxt;
    logic                       handshake;
    logic                       tick_accept;

    // Current voice operands and the wrapped phase / accumulated sum it would produce.
    always_comb begin
        cur_phase     = phase[v_idx];
        cur_inc       = phase_inc[v_idx*PHASE_W +: PHASE_W];
        cur_amp       = amplitude[v_idx*AMP_W +: AMP_W];
        cur_en        = voice_en[v_idx];
        phase_sum     = {1'b0, cur_phase} + {1'b0, cur_inc};
        phase_wrapped = (phase_sum >= PHASE_MOD) ? PHASE_W'(phase_sum - PHASE_MOD)
                                                 : PHASE_W'(phase_sum);
        product       = PROD_W'($signed(rom_data)) * PROD_W'($signed({1'b0, cur_amp}));
        sum_nxt       = cur_en ? (sum + OUT_W'(product)) : sum;
    end

    // A tick is only taken in IDLE or in the OUT cycle whose handshake completes.
    always_comb begin
        handshake   = (state == S_OUT) && mix_valid && mix_ready;
        tick_accept = sample_tick && ((state == S_IDLE) || handshake);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (sample_tick) state_nxt = S_ADDR;
            S_ADDR:  state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_MAC;
            S_MAC:   state_nxt = (v_idx == LAST_V) ? S_OUT : S_ADDR;
            S_OUT:   if (handshake) state_nxt = sample_tick ? S_ADDR : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_idx     <= '0;
            sum       <= '0;
            rom_addr  <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                phase[i] <= '0;
            end
        end else begin
            if (sample_tick && !tick_accept) begin
                overrun <= 1'b1;
            end
            if (tick_accept) begin
                sum   <= '0;
                v_idx <= '0;
            end
            case (state)
                S_ADDR: rom_addr <= cur_phase[FRAC_W +: 7];
                S_MAC: begin
                    sum          <= sum_nxt;
                    phase[v_idx] <= cur_en ? phase_wrapped : '0;
                    if (v_idx == LAST_V) begin
                        mix_out   <= sum_nxt;
                        mix_valid <= 1'b1;
                    end else begin
                        v_idx <= v_idx + 1'b1;
                    end
                end
                S_OUT: if (handshake) mix_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Bench for sine_voice_scheduler: directed scenarios plus randomized ticks compared against
// a per-tick arithmetic model of the voice mix.
module tb_sine_voice_scheduler;

    localparam int     NV      = 4;
    localparam int     PHASE_W = 23;
    localparam int     AMP_W   = 16;
    localparam int     OUT_W   = 32;
    localparam longint M       = 100 * 65536;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      sample_tick = 1'b0;
    logic                      mix_ready = 1'b0;
    logic [NV-1:0]             voice_en = '0;
    logic [NV*PHASE_W-1:0]     phase_inc = '0;
    logic [NV*AMP_W-1:0]       amplitude = '0;
    logic [6:0]                rom_addr;
    logic [7:0]                rom_data = '0;
    logic [OUT_W-1:0]          mix_out;
    logic                      mix_valid, busy, overrun;

    int                        total = 0;
    int                        bad = 0;
    int                        sine_tab [100];
    logic [7:0]                rom_mem [100];
    longint                    ref_phase [NV];
    longint                    exp_mix = 0;

    sine_voice_scheduler #(
        .NUM_VOICES(NV),
        .TABLE_LEN (100),
        .FRAC_W    (16),
        .SAMPLE_W  (8),
        .AMP_W     (AMP_W),
        .OUT_W     (OUT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_tick(sample_tick),
        .voice_en   (voice_en),
        .phase_inc  (phase_inc),
        .amplitude  (amplitude),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .mix_out    (mix_out),
        .mix_valid  (mix_valid),
        .mix_ready  (mix_ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= (rom_addr < 7'd100) ? rom_mem[rom_addr] : 8'd0;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input longint obs, input longint expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic set_voice(input int v, input logic en, input longint inc, input longint amp);
        voice_en[v] = en;
        phase_inc[v*PHASE_W +: PHASE_W] = PHASE_W'(inc);
        amplitude[v*AMP_W +: AMP_W] = AMP_W'(amp);
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) ref_phase[v] = 0;
    endtask

    // One sample: each enabled voice contributes table[phase index]*amp, then advances modulo M.
    task automatic model_tick();
        longint acc;
        acc = 0;
        for (int v = 0; v < NV; v++) begin
            longint inc, amp;
            inc = longint'(phase_inc[v*PHASE_W +: PHASE_W]);
            amp = longint'(amplitude[v*AMP_W +: AMP_W]);
            if (voice_en[v]) begin
                acc += longint'(sine_tab[ref_phase[v] / 65536]) * amp;
                ref_phase[v] = (ref_phase[v] + inc) % M;
            end else begin
                ref_phase[v] = 0;
            end
        end
        exp_mix = acc;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic tick_start();
        sample_tick = 1'b1;
        model_tick();
        @(posedge clk); #1;
        sample_tick = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 1;
        while (!mix_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, n, 13);
        check({tag, " mix_out"}, longint'($signed(mix_out)), exp_mix);
    endtask

    task automatic accept(input string tag);
        mix_ready = 1'b1;
        @(posedge clk); #1;
        mix_ready = 1'b0;
        check({tag, " valid_drop"}, mix_valid, 0);
        check({tag, " idle"}, busy, 0);
    endtask

    task automatic run_tick_exp(input string tag, input longint expected);
        tick_start();
        wait_valid(tag);
        check({tag, " const"}, longint'($signed(mix_out)), expected);
        accept(tag);
    endtask

    initial begin
        longint e2 [5] = '{0, 5, 10, 15, 19};
        longint e3 [5] = '{0, 78000, 0, -78000, 0};
        longint e4 [4] = '{0, 312, 0, -312};

        for (int i = 0; i < 100; i++) begin
            real x;
            x = 78.0 * $sin(2.0 * 3.14159265358979 * i / 100.0);
            sine_tab[i] = $rtoi(x + ((x >= 0.0) ? 0.5 : -0.5));
            rom_mem[i]  = 8'(sine_tab[i]);
        end
        model_reset();

        #12;
        check("reset mix_out", mix_out, 0);
        check("reset mix_valid", mix_valid, 0);
        check("reset busy", busy, 0);
        check("reset overrun", overrun, 0);
        check("reset rom_addr", rom_addr, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset asserted in WAIT with overrun already set.
        set_voice(0, 1'b1, 1 << 16, 1);
        run_tick_exp("t1 a", 0);
        run_tick_exp("t1 b", 5);
        tick_start();
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        check("t1 overrun set", overrun, 1);
        check("t1 wait rom_addr", rom_addr, 2);
        #3 reset = 1'b1;
        #1;
        check("t1 async mix_out", mix_out, 0);
        check("t1 async mix_valid", mix_valid, 0);
        check("t1 async busy", busy, 0);
        check("t1 async overrun", overrun, 0);
        check("t1 async rom_addr", rom_addr, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        run_tick_exp("t1 after", 0);

        do_reset();
        for (int v = 0; v < NV; v++) set_voice(v, v == 0, 1 << 16, 1);
        foreach (e2[i]) run_tick_exp("t2 ramp", e2[i]);

        do_reset();
        set_voice(0, 1'b1, 25 << 16, 1000);
        foreach (e3[i]) run_tick_exp("t3 wrap", e3[i]);

        do_reset();
        for (int v = 0; v < NV; v++) set_voice(v, 1'b1, 25 << 16, 1);
        foreach (e4[i]) run_tick_exp("t4 mix", e4[i]);
        voice_en[3] = 1'b0;
        run_tick_exp("t4 three", 0);
        voice_en[3] = 1'b1;
        run_tick_exp("t4 v3 cleared", 234);

        do_reset();
        for (int v = 0; v < NV; v++) set_voice(v, v == 0, 25 << 16, 1000);
        run_tick_exp("t5 first", 0);
        tick_start();
        wait_valid("t5 held");
        repeat (3) begin @(posedge clk); #1; end
        check("t5 hold valid", mix_valid, 1);
        check("t5 hold mix", longint'($signed(mix_out)), 78000);
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        check("t5 overrun", overrun, 1);
        check("t5 stable valid", mix_valid, 1);
        check("t5 stable mix", longint'($signed(mix_out)), 78000);
        check("t5 busy out", busy, 1);
        sample_tick = 1'b1;
        mix_ready = 1'b1;
        model_tick();
        @(posedge clk); #1;
        sample_tick = 1'b0;
        mix_ready = 1'b0;
        check("t5 accepted busy", busy, 1);
        check("t5 accepted valid", mix_valid, 0);
        wait_valid("t5 next");
        accept("t5 next");
        check("t5 sticky", overrun, 1);

        do_reset();
        for (int i = 0; i < 1500; i++) begin
            for (int v = 0; v < NV; v++) begin
                longint inc;
                inc = (i < 200 && v == 0) ? (M - 1) : longint'($urandom_range(0, 32'(M - 1)));
                set_voice(v, $urandom_range(0, 3) != 0, inc, longint'($urandom_range(0, 65535)));
            end
            tick_start();
            wait_valid("t6 rand");
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            accept("t6 rand");
        end
        check("t6 no overrun", overrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
